mmcm_drp_ctrl: RTL and testbench
================================

# mmcm_drp_ctrl

Reconfiguration sequencer for the MMCME2_ADV in the clock divider. It changes CLKFBOUT_MULT and CLKOUT0_DIVIDE at run time over the MMCM DRP port. For each request it:
- holds the MMCM in reset,
- read-modify-writes four DRP registers,
- releases the reset and waits for a stable LOCKED,
- reports done or error.

It sits beside the MMCM. DCLK is driven by the same clock as this block.

## Interface
- TIMEOUT, 4096: cycles allowed for each DRDY wait and for the lock wait before error.
- LOCK_STABLE, 16: consecutive cycles mmcm_locked must stay high to count as locked.
- clkin1  in  1  block clock; also drives MMCM DCLK.
- rst  in  1  reset, asynchronous, active-high.
- cfg_valid  in  1  request strobe.
- cfg_ready  out  1  high in IDLE only; a request is accepted when cfg_valid & cfg_ready.
- cfg_mult  in  7  integer feedback multiply; legal 2..64.
- cfg_div  in  8  integer CLKOUT0 divide; legal 1..128.
- busy  out  1  high from acceptance until done/err.
- done  out  1  one-cycle pulse on successful lock.
- err  out  1  one-cycle pulse on range, DRDY-timeout or lock-timeout failure.
- err_code  out  2  valid with err: 1 = range, 2 = DRDY timeout, 3 = lock timeout; holds until the next err.
- drp_daddr  out  7  DRP address.
- drp_den  out  1  DRP enable, one-cycle pulse per access.
- drp_dwe  out  1  DRP write enable, high only with drp_den on writes.
- drp_di  out  16  DRP write data.
- drp_do  in  16  DRP read data, sampled when drp_drdy is high.
- drp_drdy  in  1  DRP access complete.
- mmcm_rst  out  1  MMCM RST.
- mmcm_locked  in  1  MMCM LOCKED, asynchronous; double-flop synchronised internally.

## Operation
**Reset values:** cfg_ready 1 after reset, busy 0, done 0, err 0, err_code 0, drp_den 0, drp_dwe 0, drp_daddr 0, drp_di 0, mmcm_rst 0.

**Acceptance:** cfg_mult and cfg_div are latched when the request is accepted.
- If either is out of range: err pulse with err_code 1 one cycle later, no DRP activity, mmcm_rst never asserted.

**Divider encoding.** For N = mult or div:
- hi = N>>1, lo = N−hi, edge = N[0], nocnt = (N==1).
- For N==1, hi = lo = 1.

**Register writes, in order:**
- idx0: 0x08 CLKOUT0 Reg1 = (rd & 0x1000) | hi<<6 | lo (div).
- idx1: 0x09 CLKOUT0 Reg2 = (rd & 0xFC00) | edge<<7 | nocnt<<6 (div).
- idx2: 0x14 CLKFBOUT Reg1 = same form as idx0, using mult.
- idx3: 0x15 CLKFBOUT Reg2 = same form as idx1, using mult.

**FSM:**
- IDLE → CHECK on accept. CHECK → IDLE with err if out of range, else → ASSERT.
- ASSERT: mmcm_rst ← 1, idx ← 0 → RD.
- RD: den pulse, daddr = addr[idx] → RD_WAIT.
- RD_WAIT: on drdy capture drp_do → WR.
- WR: den+dwe pulse, di = merged value → WR_WAIT.
- WR_WAIT: on drdy, idx==3 → RELEASE, else idx+1 → RD.
- RELEASE: mmcm_rst ← 0 → LOCK_WAIT.
- LOCK_WAIT: synchronised locked high for LOCK_STABLE consecutive cycles → DONE. Any low sample restarts the count.
- DONE: done pulse → IDLE.

**Timeouts:**
- A timeout counter clears on every state entry.
- TIMEOUT expiry in RD_WAIT or WR_WAIT: err code 2, mmcm_rst ← 0, → IDLE.
- TIMEOUT expiry in LOCK_WAIT: err code 3, → IDLE.

**Other rules:**
- cfg_valid while busy is ignored; it is not queued.
- drp_drdy outside a WAIT state is ignored.
- rst mid-sequence: all outputs return to reset values immediately. This includes mmcm_rst → 0 and abandoning any partial DRP sequence. No done/err is issued.

## Timing
- Accept in cycle T; mmcm_rst rises at T+2.
- First drp_den at T+3.
- Each access: den at cycle t, drdy at t+k, next state action at t+k+1.
- Minimum total latency with k=1: 2 + 1 + 4×4 + 1 + 2 (sync) + LOCK_STABLE + 1 cycles to the done pulse.
- drp_daddr/drp_di stay stable from den until drdy.
- mmcm_rst stays high for the whole DRP phase and drops one cycle after the last write's drdy.

## Test plan
- mult 6, div 60; mock DRP drdy 3 cycles after den; reads return 0xFFFF → writes {0x08: 0x179E, 0x09: 0xFC00, 0x14: 0x10C3, 0x15: 0xFC00}; locked raised 20 cycles after mmcm_rst fall → done once, err 0.
- div 7, mult 5; reads return 0x0000 → 0x08 = 0x00C4, 0x09 = 0x0080, 0x14 = 0x0083, 0x15 = 0x0080.
- div 1 → 0x08 = 0x0041, 0x09 = (rd&0xFC00)|0x0040; mult 65 → err, err_code 1, zero den pulses, mmcm_rst stays 0.
- drdy withheld on second read → err code 2 exactly TIMEOUT cycles after entering RD_WAIT; mmcm_rst 0; cfg_ready 1 next cycle.
- locked toggles low after 10 high cycles then stays high → done only after 16 consecutive highs; locked never high → err code 3.
- rst asserted during WR_WAIT → mmcm_rst, busy, den drop asynchronously; a new request after reset completes normally; cfg_valid during busy has no effect.

Source files
------------

// File: rtl/mmcm_drp_ctrl.sv
// mmcm_drp_ctrl: run-time reprogramming of MMCME2_ADV CLKFBOUT_MULT / CLKOUT0_DIVIDE over DRP.
// Latency: accept at T, mmcm_rst at T+2, first DRP access at T+3, done after 4 RMW accesses + lock settle.
// Backpressure: cfg_ready is high only in IDLE; requests arriving while busy are dropped, not queued.
//
// Ports:
//   clkin1          block clock, also the MMCM DCLK
//   rst             asynchronous active-high reset
//   cfg_valid/ready request handshake; cfg_mult (2..64) and cfg_div (1..128) latched on accept
//   busy/done/err   status; done and err are one-cycle pulses, err_code holds until the next err
//   drp_*           DRP master port (daddr, den, dwe, di out; do, drdy in)
//   mmcm_rst        MMCM RST, high for the whole DRP phase
//   mmcm_locked     MMCM LOCKED (asynchronous, synchronised here)
module mmcm_drp_ctrl #(
    parameter int TIMEOUT     = 4096,
    parameter int LOCK_STABLE = 16
) (
    input  logic        clkin1,
    input  logic        rst,
    input  logic        cfg_valid,
    output logic        cfg_ready,
    input  logic [6:0]  cfg_mult,
    input  logic [7:0]  cfg_div,
    output logic        busy,
    output logic        done,
    output logic        err,
    output logic [1:0]  err_code,
    output logic [6:0]  drp_daddr,
    output logic        drp_den,
    output logic        drp_dwe,
    output logic [15:0] drp_di,
    input  logic [15:0] drp_do,
    input  logic        drp_drdy,
    output logic        mmcm_rst,
    input  logic        mmcm_locked
);

    typedef enum logic [3:0] {
        S_IDLE,
        S_CHECK,
        S_ASSERT,
        S_RD,
        S_RD_WAIT,
        S_WR,
        S_WR_WAIT,
        S_RELEASE,
        S_LOCK_WAIT,
        S_DONE
    } state_t;

    localparam int                TMR_W    = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [TMR_W-1:0]  TMR_LAST = TMR_W'(TIMEOUT - 1);
    localparam int                LK_W     = $clog2(LOCK_STABLE + 1);
    localparam logic [LK_W-1:0]   LK_LAST  = LK_W'(LOCK_STABLE - 1);

    localparam logic [1:0] ERR_RANGE = 2'd1;
    localparam logic [1:0] ERR_DRDY  = 2'd2;
    localparam logic [1:0] ERR_LOCK  = 2'd3;

    state_t            state_q, state_d;
    logic [TMR_W-1:0]  tmr_q, tmr_d;
    logic [LK_W-1:0]   lk_cnt_q, lk_cnt_d;
    logic [1:0]        idx_q, idx_d;
    logic [6:0]        mult_q, mult_d;
    logic [7:0]        div_q, div_d;
    logic              range_bad_q, range_bad_d;
    logic              locked_s1_q, locked_s2_q;

    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              err_q, err_d;
    logic [1:0]        err_code_q, err_code_d;
    logic [6:0]        daddr_q, daddr_d;
    logic              den_q, den_d;
    logic              dwe_q, dwe_d;
    logic [15:0]       di_q, di_d;
    logic              mmcm_rst_q, mmcm_rst_d;

    logic              accept;
    logic              cfg_in_range;
    logic              tmr_expired;

    // Encoder for the register currently addressed by idx_q
    logic [7:0]        enc_n;
    logic [5:0]        enc_hi;
    logic [5:0]        enc_lo;
    logic              enc_edge;
    logic              enc_nocnt;
    logic [15:0]       wr_merged;

    function automatic logic [6:0] reg_addr(input logic [1:0] idx);
        logic [6:0] a;
        case (idx)
            2'd0:    a = 7'h08;  // CLKOUT0 Reg1
            2'd1:    a = 7'h09;  // CLKOUT0 Reg2
            2'd2:    a = 7'h14;  // CLKFBOUT Reg1
            default: a = 7'h15;  // CLKFBOUT Reg2
        endcase
        return a;
    endfunction

    assign accept       = cfg_valid && (state_q == S_IDLE);
    assign cfg_in_range = (cfg_mult >= 7'd2) && (cfg_mult <= 7'd64) &&
                          (cfg_div != 8'd0)  && (cfg_div <= 8'd128);
    assign tmr_expired  = (tmr_q == TMR_LAST);

    // idx 0/1 program CLKOUT0 from the divide, idx 2/3 program CLKFBOUT from the multiply.
    // High/low times live in 6-bit fields; a count of 64 wraps to 0, which the MMCM reads as 64.
    always_comb begin
        enc_n     = idx_q[1] ? {1'b0, mult_q} : div_q;
        enc_nocnt = (enc_n == 8'd1);
        enc_edge  = enc_n[0];
        enc_hi    = enc_n[6:1];
        enc_lo    = enc_n[5:0] - enc_n[6:1];
        if (enc_nocnt) begin
            enc_hi = 6'd1;
            enc_lo = 6'd1;
        end
        if (idx_q[0]) begin
            wr_merged = (drp_do & 16'hFC00) | {8'h00, enc_edge, enc_nocnt, 6'h00};
        end else begin
            wr_merged = (drp_do & 16'h1000) | {4'h0, enc_hi, enc_lo};
        end
    end

    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        mult_d      = mult_q;
        div_d       = div_q;
        range_bad_d = range_bad_q;
        lk_cnt_d    = '0;
        done_d      = 1'b0;
        err_d       = 1'b0;
        err_code_d  = err_code_q;
        daddr_d     = daddr_q;
        den_d       = 1'b0;
        dwe_d       = 1'b0;
        di_d        = di_q;
        mmcm_rst_d  = mmcm_rst_q;

        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    mult_d      = cfg_mult;
                    div_d       = cfg_div;
                    range_bad_d = !cfg_in_range;
                    state_d     = S_CHECK;
                    // Range error is flagged straight from the inputs so the pulse lands in CHECK.
                    if (!cfg_in_range) begin
                        err_d      = 1'b1;
                        err_code_d = ERR_RANGE;
                    end
                end
            end
            S_CHECK: begin
                if (range_bad_q) begin
                    state_d = S_IDLE;
                end else begin
                    state_d    = S_ASSERT;
                    mmcm_rst_d = 1'b1;
                    idx_d      = 2'd0;
                end
            end
            S_ASSERT: begin
                state_d = S_RD;
                den_d   = 1'b1;
                daddr_d = reg_addr(idx_q);
            end
            S_RD: begin
                state_d = S_RD_WAIT;
            end
            S_RD_WAIT: begin
                if (drp_drdy) begin
                    state_d = S_WR;
                    den_d   = 1'b1;
                    dwe_d   = 1'b1;
                    di_d    = wr_merged;
                end else if (tmr_expired) begin
                    state_d    = S_IDLE;
                    err_d      = 1'b1;
                    err_code_d = ERR_DRDY;
                    mmcm_rst_d = 1'b0;
                end
            end
            S_WR: begin
                state_d = S_WR_WAIT;
            end
            S_WR_WAIT: begin
                if (drp_drdy) begin
                    if (idx_q == 2'd3) begin
                        state_d    = S_RELEASE;
                        mmcm_rst_d = 1'b0;
                    end else begin
                        state_d = S_RD;
                        idx_d   = idx_q + 2'd1;
                        den_d   = 1'b1;
                        daddr_d = reg_addr(idx_q + 2'd1);
                    end
                end else if (tmr_expired) begin
                    state_d    = S_IDLE;
                    err_d      = 1'b1;
                    err_code_d = ERR_DRDY;
                    mmcm_rst_d = 1'b0;
                end
            end
            S_RELEASE: begin
                state_d = S_LOCK_WAIT;
            end
            S_LOCK_WAIT: begin
                // Any low sample drops the run length back to zero.
                if (locked_s2_q) begin
                    lk_cnt_d = lk_cnt_q + 1'b1;
                end
                if (locked_s2_q && (lk_cnt_q == LK_LAST)) begin
                    state_d = S_DONE;
                    done_d  = 1'b1;
                end else if (tmr_expired) begin
                    state_d    = S_IDLE;
                    err_d      = 1'b1;
                    err_code_d = ERR_LOCK;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d    = S_IDLE;
                mmcm_rst_d = 1'b0;
            end
        endcase

        busy_d = (state_d != S_IDLE);

        // Timeout counter restarts on every state entry and only runs in the wait states.
        tmr_d = '0;
        if ((state_d == state_q) &&
            ((state_q == S_RD_WAIT) || (state_q == S_WR_WAIT) || (state_q == S_LOCK_WAIT))) begin
            tmr_d = tmr_q + 1'b1;
        end
    end

    always_ff @(posedge clkin1 or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            tmr_q       <= '0;
            lk_cnt_q    <= '0;
            idx_q       <= 2'd0;
            mult_q      <= 7'd0;
            div_q       <= 8'd0;
            range_bad_q <= 1'b0;
            locked_s1_q <= 1'b0;
            locked_s2_q <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
            err_code_q  <= 2'd0;
            daddr_q     <= 7'd0;
            den_q       <= 1'b0;
            dwe_q       <= 1'b0;
            di_q        <= 16'd0;
            mmcm_rst_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            tmr_q       <= tmr_d;
            lk_cnt_q    <= lk_cnt_d;
            idx_q       <= idx_d;
            mult_q      <= mult_d;
            div_q       <= div_d;
            range_bad_q <= range_bad_d;
            locked_s1_q <= mmcm_locked;
            locked_s2_q <= locked_s1_q;
            busy_q      <= busy_d;
            done_q      <= done_d;
            err_q       <= err_d;
            err_code_q  <= err_code_d;
            daddr_q     <= daddr_d;
            den_q       <= den_d;
            dwe_q       <= dwe_d;
            di_q        <= di_d;
            mmcm_rst_q  <= mmcm_rst_d;
        end
    end

    assign cfg_ready = (state_q == S_IDLE);
    assign busy      = busy_q;
    assign done      = done_q;
    assign err       = err_q;
    assign err_code  = err_code_q;
    assign drp_daddr = daddr_q;
    assign drp_den   = den_q;
    assign drp_dwe   = dwe_q;
    assign drp_di    = di_q;
    assign mmcm_rst  = mmcm_rst_q;

endmodule

// File: tb/tb_mmcm_drp_ctrl.sv
// Bench for mmcm_drp_ctrl: mock DRP slave and MMCM lock model, expected writes and
// outcomes queued at request time, a negedge monitor pops and compares them.
module tb_mmcm_drp_ctrl;

    localparam int TIMEOUT     = 4096;
    localparam int LOCK_STABLE = 16;

    logic        clk = 1'b0;
    logic        rst;
    logic        cfg_valid;
    logic        cfg_ready;
    logic [6:0]  cfg_mult;
    logic [7:0]  cfg_div;
    logic        busy;
    logic        done;
    logic        err;
    logic [1:0]  err_code;
    logic [6:0]  drp_daddr;
    logic        drp_den;
    logic        drp_dwe;
    logic [15:0] drp_di;
    logic [15:0] drp_do;
    logic        drp_drdy;
    logic        mmcm_rst;
    logic        mmcm_locked;

    mmcm_drp_ctrl #(.TIMEOUT(TIMEOUT), .LOCK_STABLE(LOCK_STABLE)) dut (
        .clkin1     (clk),
        .rst        (rst),
        .cfg_valid  (cfg_valid),
        .cfg_ready  (cfg_ready),
        .cfg_mult   (cfg_mult),
        .cfg_div    (cfg_div),
        .busy       (busy),
        .done       (done),
        .err        (err),
        .err_code   (err_code),
        .drp_daddr  (drp_daddr),
        .drp_den    (drp_den),
        .drp_dwe    (drp_dwe),
        .drp_di     (drp_di),
        .drp_do     (drp_do),
        .drp_drdy   (drp_drdy),
        .mmcm_rst   (mmcm_rst),
        .mmcm_locked(mmcm_locked)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_vec = 0;
    int n_bad = 0;

    // Scoreboard: expected writes and outcomes (0 = done, 1..3 = err_code)
    int exp_wr_addr[$];
    int exp_wr_data[$];
    int exp_ev[$];

    // Mock DRP slave state
    logic [15:0] mem [0:127];
    int k_lat = 1;
    int withhold_rd = 0;
    int rd_count = 0;
    int pend = 0;
    int pend_addr = 0;

    // Lock model state
    int lock_mode = 0;   // 0 steady after delay, 1 one low glitch after 10 highs, 2 never
    int lock_dly = 5;
    int fall_cyc = -1;
    int lt;
    bit seen_hi = 0;

    // Monitor observations
    int den_count = 0;
    int last_den_cyc = -1;
    int first_den_cyc = -1;
    int den_addr = 0;
    int rst_rise_cyc = -1;
    int ev_cyc = -1;
    int ev_mrst = 0;
    int last_err = 0;
    int ev;
    int e;

    task automatic check(input string name, input int got, input int exp);
        n_vec++;
        if (got != exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, got, exp, cyc);
        end
    endtask

    function automatic int addr_of(input int idx);
        case (idx)
            0: return 'h08;
            1: return 'h09;
            2: return 'h14;
            default: return 'h15;
        endcase
    endfunction

    // Reference register contents from the divider encoding rules.
    function automatic int model_reg(input int idx, input int rd, input int n);
        int hi;
        int lo;
        hi = n / 2;
        lo = n - hi;
        if (n == 1) begin
            hi = 1;
            lo = 1;
        end
        if (idx % 2 == 0)
            return (rd & 'h1000) | ((hi % 64) * 64) | (lo % 64);
        else
            return (rd & 'hFC00) | ((n % 2) * 128) | ((n == 1) ? 64 : 0);
    endfunction

    // Mock DRP slave: drdy k_lat cycles after den, reads return mem, writes update mem.
    initial begin
        drp_drdy = 1'b0;
        drp_do   = 16'h0;
        forever begin
            @(posedge clk);
            #1;
            drp_drdy = 1'b0;
            if (rst) begin
                pend = 0;
            end else begin
                if (pend > 0) begin
                    pend--;
                    if (pend == 0) begin
                        drp_drdy = 1'b1;
                        drp_do   = mem[pend_addr];
                    end
                end
                if (drp_den) begin
                    pend_addr = int'(drp_daddr);
                    if (drp_dwe) begin
                        mem[drp_daddr] = drp_di;
                        pend = k_lat;
                    end else begin
                        rd_count++;
                        pend = (rd_count == withhold_rd) ? 0 : k_lat;
                    end
                end
            end
        end
    end

    // MMCM lock model, timed from the first cycle mmcm_rst is seen low.
    initial begin
        mmcm_locked = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            if (mmcm_rst) begin
                seen_hi = 1;
                mmcm_locked = 1'b0;
            end else begin
                if (seen_hi) begin
                    seen_hi = 0;
                    fall_cyc = cyc;
                end
                lt = cyc - fall_cyc;
                if (fall_cyc < 0 || lock_mode == 2)
                    mmcm_locked = 1'b0;
                else if (lock_mode == 1)
                    mmcm_locked = (lt >= lock_dly) && (lt != lock_dly + 10);
                else
                    mmcm_locked = (lt >= lock_dly);
            end
        end
    end

    // Monitor
    always @(negedge clk) begin
        if (!rst) begin
            if (drp_den) begin
                den_count++;
                last_den_cyc = cyc;
                den_addr = int'(drp_daddr);
                if (first_den_cyc < 0) first_den_cyc = cyc;
                check("mrst_high_during_drp", int'(mmcm_rst), 1);
                check("busy_during_drp", int'(busy), 1);
                if (drp_dwe) begin
                    if (exp_wr_addr.size() == 0) begin
                        check("unexpected_write", int'(drp_daddr) + 256, 0);
                    end else begin
                        check("wr_addr", int'(drp_daddr), exp_wr_addr.pop_front());
                        check("wr_data", int'(drp_di), exp_wr_data.pop_front());
                    end
                end
            end else if (drp_dwe) begin
                check("dwe_without_den", 1, 0);
            end
            if (drp_drdy) check("daddr_stable", int'(drp_daddr), den_addr);
            if (mmcm_rst && rst_rise_cyc < 0) rst_rise_cyc = cyc;
            if (done || err) begin
                ev = done ? 0 : int'(err_code);
                ev_cyc = cyc;
                ev_mrst = int'(mmcm_rst);
                if (exp_ev.size() == 0) begin
                    check("unexpected_event", ev + 16, 0);
                end else begin
                    e = exp_ev.pop_front();
                    check("outcome", ev, e);
                    if (e != 0) last_err = e;
                end
                if (done) check("err_code_hold", int'(err_code), last_err);
            end
        end
    end

    // One request: queue expectations, issue, wait for the outcome, check timing.
    task automatic run_req(input int m, input int d, input int k, input int ldly,
                           input int lmode, input int wh, input bit poke);
        bit ok;
        int nwr;
        int t_acc;
        int c;
        int den0;
        ok = (m >= 2 && m <= 64) && (d >= 1 && d <= 128);
        k_lat = k;
        lock_dly = ldly;
        lock_mode = lmode;
        withhold_rd = wh;
        rd_count = 0;
        first_den_cyc = -1;
        rst_rise_cyc = -1;
        den0 = den_count;
        if (!ok) begin
            exp_ev.push_back(1);
        end else begin
            nwr = (wh == 0) ? 4 : wh - 1;
            for (int i = 0; i < nwr; i++) begin
                exp_wr_addr.push_back(addr_of(i));
                exp_wr_data.push_back(model_reg(i, int'(mem[addr_of(i)]), (i < 2) ? d : m));
            end
            exp_ev.push_back((wh != 0) ? 2 : ((lmode == 2) ? 3 : 0));
        end
        c = 0;
        while (!cfg_ready && c < 100) begin
            @(posedge clk);
            #1;
            c++;
        end
        check("ready_before_req", int'(cfg_ready), 1);
        cfg_valid = 1'b1;
        cfg_mult  = 7'(m);
        cfg_div   = 8'(d);
        t_acc = cyc;
        @(posedge clk);
        #1;
        cfg_valid = 1'b0;
        c = 0;
        while (exp_ev.size() != 0 && c < 2 * TIMEOUT + 500) begin
            if (poke && ok) begin
                if (c >= 2 && c <= 6) begin
                    check("ready_low_while_busy", int'(cfg_ready), 0);
                    cfg_valid = 1'b1;
                    cfg_mult  = 7'd3;
                    cfg_div   = 8'd3;
                end else begin
                    cfg_valid = 1'b0;
                end
            end
            @(posedge clk);
            #1;
            c++;
        end
        cfg_valid = 1'b0;
        if (exp_ev.size() != 0) begin
            check("no_outcome_within_budget", 0, 1);
            exp_ev.delete();
        end
        check("ready_after_outcome", int'(cfg_ready), 1);
        if (!ok) begin
            check("range_err_cycle", ev_cyc - t_acc, 1);
            check("range_no_den", den_count - den0, 0);
            check("range_no_mrst", rst_rise_cyc, -1);
        end else begin
            check("mrst_rise_cycle", rst_rise_cyc - t_acc, 2);
            check("first_den_cycle", first_den_cyc - t_acc, 3);
            if (wh != 0) begin
                check("drdy_timeout_cycle", ev_cyc - last_den_cyc, TIMEOUT + 1);
                check("mrst_low_at_timeout", ev_mrst, 0);
            end else if (lmode == 0) begin
                check("done_latency", ev_cyc - fall_cyc, ldly + 2 + LOCK_STABLE);
            end else if (lmode == 1) begin
                check("done_after_glitch", ev_cyc - fall_cyc, ldly + 13 + LOCK_STABLE);
            end else begin
                check("lock_timeout_cycle", ev_cyc - fall_cyc, TIMEOUT + 1);
            end
        end
        if (exp_wr_addr.size() != 0) begin
            check("missing_writes", exp_wr_addr.size(), 0);
            exp_wr_addr.delete();
            exp_wr_data.delete();
        end
    endtask

    task automatic fill_mem(input int v);
        for (int i = 0; i < 4; i++)
            mem[addr_of(i)] = (v < 0) ? 16'($urandom) : 16'(v);
    endtask

    initial begin
        int c;
        int m;
        int d;
        for (int i = 0; i < 128; i++) mem[i] = 16'h0;
        rst = 1'b1;
        cfg_valid = 1'b0;
        cfg_mult = 7'd0;
        cfg_div = 8'd0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_cfg_ready", int'(cfg_ready), 1);
        check("rst_busy", int'(busy), 0);
        check("rst_done", int'(done), 0);
        check("rst_err", int'(err), 0);
        check("rst_err_code", int'(err_code), 0);
        check("rst_den", int'(drp_den), 0);
        check("rst_dwe", int'(drp_dwe), 0);
        check("rst_daddr", int'(drp_daddr), 0);
        check("rst_di", int'(drp_di), 0);
        check("rst_mmcm_rst", int'(mmcm_rst), 0);
        rst = 1'b0;
        @(posedge clk);
        #1;

        fill_mem('hFFFF);
        run_req(6, 60, 3, 20, 0, 0, 1);
        fill_mem(0);
        run_req(5, 7, 1, 5, 0, 0, 0);
        fill_mem(-1);
        run_req(12, 1, 2, 8, 0, 0, 0);
        run_req(65, 10, 1, 5, 0, 0, 0);
        run_req(1, 10, 1, 5, 0, 0, 0);
        run_req(10, 0, 1, 5, 0, 0, 0);
        run_req(10, 129, 1, 5, 0, 0, 0);
        fill_mem(-1);
        run_req(64, 128, 1, 3, 0, 0, 0);
        fill_mem(-1);
        run_req(2, 1, 4, 1, 0, 0, 0);
        fill_mem(-1);
        run_req(8, 8, 1, 5, 0, 2, 0);
        fill_mem(-1);
        run_req(9, 9, 2, 10, 1, 0, 0);
        fill_mem(-1);
        run_req(9, 9, 1, 5, 2, 0, 0);
        fill_mem(-1);
        run_req(7, 3, 1, 4, 0, 0, 0);

        // Reset while the first write is outstanding
        fill_mem(-1);
        k_lat = 2;
        withhold_rd = 0;
        rd_count = 0;
        lock_mode = 0;
        exp_wr_addr.push_back('h08);
        exp_wr_data.push_back(model_reg(0, int'(mem['h08]), 20));
        cfg_valid = 1'b1;
        cfg_mult = 7'd10;
        cfg_div = 8'd20;
        @(posedge clk);
        #1;
        cfg_valid = 1'b0;
        c = 0;
        while (!(drp_den && drp_dwe) && c < 100) begin
            @(posedge clk);
            #1;
            c++;
        end
        check("reached_first_write", int'(drp_den && drp_dwe), 1);
        @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        check("arst_mmcm_rst", int'(mmcm_rst), 0);
        check("arst_busy", int'(busy), 0);
        check("arst_den", int'(drp_den), 0);
        check("arst_done", int'(done), 0);
        check("arst_err", int'(err), 0);
        check("arst_err_code", int'(err_code), 0);
        check("arst_cfg_ready", int'(cfg_ready), 1);
        exp_wr_addr.delete();
        exp_wr_data.delete();
        exp_ev.delete();
        last_err = 0;
        repeat (2) @(posedge clk);
        #3;
        rst = 1'b0;
        @(posedge clk);
        #1;
        fill_mem(-1);
        run_req(10, 20, 2, 6, 0, 0, 0);

        for (int it = 0; it < 25; it++) begin
            m = ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, 127)) : int'($urandom_range(2, 64));
            d = ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, 255)) : int'($urandom_range(1, 128));
            fill_mem(-1);
            run_req(m, d, int'($urandom_range(1, 5)), int'($urandom_range(1, 30)),
                    int'($urandom_range(0, 1)), 0, it[0]);
        end

        repeat (5) @(posedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
